// File: rtl/io_handshake_ctrl_pkg.sv
// Shared definitions for the IN/OUT handshake controller: FSM encoding and
// default sizing parameters.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SW_WIDTH        = 15;
  localparam int DEFAULT_DATA_WIDTH      = 32;

endpackage

// File: rtl/io_handshake_ctrl_if.sv
// Bundle of control-unit, board-I/O and display signals around the handshake
// controller. master = processor/board side, slave = the controller.
interface io_handshake_ctrl_if
  import io_pkg::*;
#(
  parameter int SW_WIDTH   = DEFAULT_SW_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  // Handshake: in_req is held by the control unit while an IN is decoded;
  // stall stays high until in_valid pulses for exactly one cycle, during which
  // stall is low, in_data is valid and the register file must write it.
  logic                  in_req;
  logic                  out_req;
  logic                  confirm_key;
  logic [SW_WIDTH-1:0]   switches;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  stall;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] disp_data;
  logic                  waiting;
  state_e                dbg_state;

  modport master (
    output in_req, out_req, confirm_key, switches, alu_result,
    input  stall, in_data, in_valid, disp_data, waiting, dbg_state
  );

  modport slave (
    input  in_req, out_req, confirm_key, switches, alu_result,
    output stall, in_data, in_valid, disp_data, waiting, dbg_state
  );

endinterface

// File: rtl/io_handshake_ctrl_debounce.sv
// Confirm-key conditioning: two-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = io_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES,
  // so a clean press shows up 2 + DEBOUNCE_CYCLES edges after the raw rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/io_handshake_ctrl.sv
// IN/OUT instruction sequencer: stalls the PC on IN until a fresh debounced
// confirm press, captures the switches, and latches OUT values for display.
module io_handshake_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH        = DEFAULT_SW_WIDTH,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  io_handshake_ctrl_if.slave  bus
);

  state_e                r_state;
  state_e                w_next;
  logic [DATA_WIDTH-1:0] r_in_data;
  logic [DATA_WIDTH-1:0] r_disp_data;
  logic                  w_level;
  logic                  w_rise;
  logic                  w_capture;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .raw   (bus.confirm_key),
    .level (w_level),
    .rise  (w_rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Only a rise can leave WAIT_PRESS, so a key already held when the IN
  // arrives, or the same press seen again via WAIT_RELEASE, never captures.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_req) w_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (w_rise) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = w_level ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (!w_level) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_data   <= '0;
      r_disp_data <= '0;
    end else begin
      if (w_capture) r_in_data <= DATA_WIDTH'(bus.switches);
      // IN wins when both are decoded together; the OUT is dropped.
      if (bus.out_req && !bus.in_req) r_disp_data <= bus.alu_result;
    end
  end

  assign bus.stall     = bus.in_req && (r_state != DONE);
  assign bus.in_valid  = (r_state == DONE);
  assign bus.waiting   = (r_state == WAIT_PRESS);
  assign bus.in_data   = r_in_data;
  assign bus.disp_data = r_disp_data;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Bench for io_handshake_ctrl with a short debounce window: directed
// sequences, with captured IN data checked through an expected-value queue.
module tb_io_handshake_ctrl;
  import io_pkg::*;

  localparam int DB = 4;
  localparam int SW = 15;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  io_handshake_ctrl_if #(.SW_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  io_handshake_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SW_WIDTH       (SW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_pulses = 0;
  logic prev_valid = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every in_valid cycle pops one expected capture.
  always @(negedge clock) begin
    if (reset !== 1'b0) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.in_valid === 1'b1) begin
        valid_pulses++;
        check("in_valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_in_valid: got in_data 0x%0h expected no strobe at %0t",
                   bus.in_data, $time);
        end else begin
          check("in_data", bus.in_data, exp_q.pop_front());
        end
      end
      prev_valid = bus.in_valid;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Wait for the DONE strobe; while waiting the processor must stay stalled.
  task automatic wait_valid(input int bound, output int cycles);
    cycles = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      cycles++;
      if (bus.in_valid === 1'b1) break;
      check("stall_while_waiting", {31'd0, bus.stall}, 32'd1);
      check("waiting_led", {31'd0, bus.waiting}, 32'd1);
    end
    if (bus.in_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid_timeout: got no in_valid expected one within %0d cycles", bound);
    end
  endtask

  task automatic wait_state(input state_e st, input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (bus.dbg_state == st) begin
        seen = 1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int cyc;
    bus.in_req      = 1'b0;
    bus.out_req     = 1'b0;
    bus.confirm_key = 1'b0;
    bus.switches    = '0;
    bus.alu_result  = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_waiting", {31'd0, bus.waiting}, 32'd0);
    check("rst_in_valid", {31'd0, bus.in_valid}, 32'd0);
    check("rst_in_data", bus.in_data, 32'd0);
    check("rst_disp", bus.disp_data, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});

    // OUT pulse
    step();
    bus.out_req = 1'b1;
    bus.alu_result = 32'd123;
    step();
    bus.out_req = 1'b0;
    @(negedge clock);
    check("out_disp", bus.disp_data, 32'd123);
    check("out_no_stall", {31'd0, bus.stall}, 32'd0);

    // IN with clean press
    step();
    bus.switches = 15'h1A5;
    bus.in_req = 1'b1;
    @(negedge clock);
    check("in_stall_same_cycle", {31'd0, bus.stall}, 32'd1);
    check("in_idle_not_waiting", {31'd0, bus.waiting}, 32'd0);
    step();
    exp_q.push_back(32'h0000_01A5);
    bus.confirm_key = 1'b1;
    wait_valid(20, cyc);
    check("press_latency", cyc, 32'd8);
    check("done_stall_low", {31'd0, bus.stall}, 32'd0);

    // Key held through a second IN: no capture until release and re-press
    step();
    bus.switches = 15'h2B6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("held_stall", {31'd0, bus.stall}, 32'd1);
      check("held_state", {30'd0, bus.dbg_state}, {30'd0, WAIT_RELEASE});
    end
    step();
    bus.confirm_key = 1'b0;
    wait_state(WAIT_PRESS, 30, "release_to_wait_press");

    // Bounce with 2-cycle pulses
    step();
    for (int p = 0; p < 4; p++) begin
      bus.confirm_key = (p % 2 == 0);
      step();
      step();
    end
    bus.confirm_key = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("bounce_stall", {31'd0, bus.stall}, 32'd1);
      check("bounce_waiting", {31'd0, bus.waiting}, 32'd1);
    end
    step();
    exp_q.push_back(32'h0000_02B6);
    bus.confirm_key = 1'b1;
    wait_valid(20, cyc);
    check("second_press_latency", cyc, 32'd8);
    step();
    bus.in_req = 1'b0;
    bus.confirm_key = 1'b0;
    wait_state(IDLE, 20, "back_to_idle");
    check("in_data_held", bus.in_data, 32'h0000_02B6);

    // Simultaneous IN and OUT: IN wins
    step();
    bus.in_req = 1'b1;
    bus.out_req = 1'b1;
    bus.alu_result = 32'd99;
    step();
    bus.out_req = 1'b0;
    @(negedge clock);
    check("both_disp_unchanged", bus.disp_data, 32'd123);
    check("both_state", {30'd0, bus.dbg_state}, {30'd0, WAIT_PRESS});
    check("both_waiting", {31'd0, bus.waiting}, 32'd1);

    // Reset mid WAIT_PRESS
    step();
    bus.in_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
    check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("mid_rst_disp", bus.disp_data, 32'd0);
    check("mid_rst_waiting", {31'd0, bus.waiting}, 32'd0);
    check("mid_rst_in_data", bus.in_data, 32'd0);

    repeat (2) @(negedge clock);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("valid_pulse_count", valid_pulses, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
